// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: fetch/decode/exec/mem/writeback with cache-hit handshakes,
// a bounded-wait watchdog and terminal HALT/ERROR states. Optional macro CU_PERF_CNT_EN adds perf counters.
package cpu_types_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000,
    ALU_SRL  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SLT  = 4'b1010,
    ALU_SLTU = 4'b1011
  } aluop_t;
endpackage

module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int          WORD_W     = 32,
  parameter int          WAIT_LIMIT = 16,
  parameter logic [5:0]  HALT_OP    = 6'h3F
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] instr,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              zero,
  output logic              icuREN,
  output logic              dcuREN,
  output logic              dcuWEN,
  output logic              ir_wen,
  output logic              pc_wen,
  output logic [1:0]        pc_src,
  output logic              regwr,
  output logic [1:0]        regdst,
  output logic              memtoreg,
  output logic [1:0]        alu_src,
  output logic              extop,
  output aluop_t            alu_op,
  output logic              halt,
  output logic              err,
  output logic [2:0]        state
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  localparam int CNT_W = $clog2(WAIT_LIMIT + 2);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  logic [5:0] op, funct;
  logic       is_rtype, is_lw, is_sw, is_jal;
  logic       timeout;
  logic       unused_ir_bits;

  assign op             = ir_q[WORD_W-1 -: 6];
  assign funct          = ir_q[5:0];
  assign is_rtype       = (op == OP_RTYPE);
  assign is_lw          = (op == OP_LW);
  assign is_sw          = (op == OP_SW);
  assign is_jal         = (op == OP_JAL);
  assign unused_ir_bits = ^ir_q[WORD_W-7:6];
  assign timeout        = (WAIT_LIMIT != 0) && (wait_q == LAST_WAIT);
  assign state          = state_q;

  aluop_t     dec_alu;
  logic [1:0] dec_src;
  logic       dec_ext;
  logic       dec_valid;

  always_comb begin
    dec_alu   = ALU_ADD;
    dec_src   = 2'd0;
    dec_ext   = 1'b0;
    dec_valid = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU:  dec_alu = ALU_ADD;
          F_SUBU:  dec_alu = ALU_SUB;
          F_AND:   dec_alu = ALU_AND;
          F_OR:    dec_alu = ALU_OR;
          F_XOR:   dec_alu = ALU_XOR;
          F_NOR:   dec_alu = ALU_NOR;
          F_SLT:   dec_alu = ALU_SLT;
          F_SLTU:  dec_alu = ALU_SLTU;
          F_SLL:   dec_alu = ALU_SLL;
          F_SRL:   dec_alu = ALU_SRL;
          default: dec_valid = 1'b0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: begin
        dec_src = 2'd1;
        dec_ext = 1'b1;
      end
      OP_SLTI: begin
        dec_alu = ALU_SLT;
        dec_src = 2'd1;
        dec_ext = 1'b1;
      end
      OP_ANDI: begin dec_alu = ALU_AND; dec_src = 2'd1; end
      OP_ORI:  begin dec_alu = ALU_OR;  dec_src = 2'd1; end
      OP_XORI: begin dec_alu = ALU_XOR; dec_src = 2'd1; end
      OP_LUI:  dec_src = 2'd2;
      OP_BEQ, OP_BNE: dec_alu = ALU_SUB;
      default: dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    icuREN   = 1'b0;
    dcuREN   = 1'b0;
    dcuWEN   = 1'b0;
    ir_wen   = 1'b0;
    pc_wen   = 1'b0;
    pc_src   = 2'd0;
    regwr    = 1'b0;
    regdst   = 2'd0;
    memtoreg = 1'b0;
    alu_src  = 2'd0;
    extop    = 1'b0;
    alu_op   = ALU_ADD;
    halt     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_FETCH: begin
        icuREN = 1'b1;
        if (ihit) begin
          ir_wen  = 1'b1;
          pc_wen  = 1'b1;
          ir_d    = instr;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        if (op == HALT_OP) begin
          state_d = S_HALT;
        end else if (op == OP_J || is_jal) begin
          pc_wen  = 1'b1;
          pc_src  = 2'd2;
          regdst  = is_jal ? 2'd2 : 2'd0;
          state_d = is_jal ? S_WB : S_FETCH;
        end else if (is_rtype && funct == F_JR) begin
          pc_wen  = 1'b1;
          pc_src  = 2'd3;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = dec_alu;
        alu_src = dec_src;
        extop   = dec_ext;
        if (!dec_valid) begin
          state_d = S_FETCH;
        end else if (op == OP_BEQ || op == OP_BNE) begin
          pc_src  = 2'd1;
          pc_wen  = (op == OP_BEQ) ? zero : ~zero;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dcuREN = is_lw;
        dcuWEN = is_sw;
        if (dhit) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        regwr    = 1'b1;
        memtoreg = is_lw;
        regdst   = is_rtype ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
        state_d  = S_FETCH;
      end
      S_HALT:  halt = 1'b1;
      S_ERROR: err  = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Reset wins over the current state so no request escapes while RST is held.
    if (RST) begin
      icuREN   = 1'b0;
      dcuREN   = 1'b0;
      dcuWEN   = 1'b0;
      ir_wen   = 1'b0;
      pc_wen   = 1'b0;
      pc_src   = 2'd0;
      regwr    = 1'b0;
      regdst   = 2'd0;
      memtoreg = 1'b0;
      alu_src  = 2'd0;
      extop    = 1'b0;
      alu_op   = ALU_ADD;
      halt     = 1'b0;
      err      = 1'b0;
    end
  end

  always_comb begin
    wait_d = '0;
    if (state_d == state_q && (state_q == S_FETCH || state_q == S_MEM)) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

`ifdef CU_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != S_HALT && state_q != S_ERROR) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if (state_q == S_FETCH && state_d == S_DECODE) begin
        instr_cnt_q <= instr_cnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule
